// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
//   Shared definitions for the modular-exponentiation engine:
//   - DEFAULT_WIDTH : default half operand width (operands are 2*WIDTH bits)
//   - state_t       : engine FSM states
//   - op_t / OP_*   : multiplier operand-select (square or multiply by base)
// ---------------------------------------------------------------------------
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SQR,
    MUL,
    DONE
  } state_t;

  // Selects the multiplier's B operand: the accumulator itself or the base.
  typedef logic op_t;
  localparam op_t OP_SQR = 1'b0;
  localparam op_t OP_MUL = 1'b1;

endpackage

// File: rtl/rsa_mod_mul.sv
// ---------------------------------------------------------------------------
// rsa_mod_mul
//   Bit-serial Blakley modular multiplier: p = a*b mod m in exactly N cycles.
//   Each cycle consumes one bit of a (MSB first):
//     R = 2R + a[i]*b ; then up to two conditional subtractions of m.
//   Requires a, b < m; R < m holds after every step.
//
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     go         : one-cycle pulse; this cycle performs the first step
//     a, b, m    : operands (must stay stable for the N cycles)
//     done       : high during the Nth (final) step cycle
//     p          : product, valid while done is high
// ---------------------------------------------------------------------------
module rsa_mod_mul #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic         done,
  output logic [N-1:0] p
);

  localparam int IW = $clog2(N);

  logic [N+1:0]  r;
  logic [IW-1:0] idx;
  logic          active;

  logic [N+1:0]  r_base;
  logic [N+1:0]  m_ext;
  logic [N+1:0]  t0;
  logic [N+1:0]  t1;
  logic [N+1:0]  t2;
  logic          bit_sel;

  // The go cycle starts from R=0 with the MSB so consecutive operations
  // run back to back without an idle load cycle.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    m_ext   = {2'b00, m};
    r_base  = go ? '0 : r;
    bit_sel = go ? a[N-1] : a[idx];
    t0      = (r_base << 1) + (bit_sel ? {2'b00, b} : '0);
    t1      = (t0 >= m_ext) ? t0 - m_ext : t0;
    t2      = (t1 >= m_ext) ? t1 - m_ext : t1;
  end

  assign p    = t2[N-1:0];
  assign done = active && (idx == '0) && !go;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r      <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (go) begin
      r      <= t2;
      idx    <= IW'(N - 2);
      active <= 1'b1;
    end else if (active) begin
      r <= t2;
      if (idx == '0) active <= 1'b0;
      else           idx    <= idx - 1'b1;
    end
  end

endmodule

// File: rtl/rsa_mod_exp_engine.sv
// ---------------------------------------------------------------------------
// rsa_mod_exp_engine
//   Computes result = base^exponent mod modulus with left-to-right
//   square-and-multiply over rsa_mod_mul. Every exponent bit costs one
//   square; set bits add one multiply. Leading zeros are not skipped.
//
//   Ports (N = 2*WIDTH):
//     clk, reset : clock, asynchronous active-high reset
//     start      : request pulse, honoured only in IDLE
//     base       : must be < modulus
//     exponent   : exponent (e or d)
//     modulus    : n
//     busy       : high from the cycle after an accepted start until finish
//     finish     : one-cycle completion pulse
//     err        : with finish; modulus==0 or base>=modulus
//     result     : final value, held until the next accepted start
// ---------------------------------------------------------------------------
module rsa_mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   base,
  input  logic [2*WIDTH-1:0]   exponent,
  input  logic [2*WIDTH-1:0]   modulus,
  output logic                 busy,
  output logic                 finish,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N  = 2 * WIDTH;
  localparam int KW = $clog2(N);

  state_t        state;
  logic [N-1:0]  base_q;
  logic [N-1:0]  exp_q;
  logic [N-1:0]  mod_q;
  logic [N-1:0]  acc;
  logic [KW-1:0] k;
  op_t           op;
  logic          mul_go;
  logic          mul_done;
  logic [N-1:0]  mul_b;
  logic [N-1:0]  mul_p;

  assign mul_b = (op == OP_MUL) ? base_q : acc;

  rsa_mod_mul #(.N(N)) u_mul (
    .clk   (clk),
    .reset (reset),
    .go    (mul_go),
    .a     (acc),
    .b     (mul_b),
    .m     (mod_q),
    .done  (mul_done),
    .p     (mul_p)
  );

  // mul_go is registered: it is raised on the edge that ends one operation
  // (or leaves CHECK), so the next operation's first step follows directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      acc    <= '0;
      k      <= '0;
      op     <= OP_SQR;
      mul_go <= 1'b0;
      busy   <= 1'b0;
      finish <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      mul_go <= 1'b0;
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exponent;
            mod_q  <= modulus;
            result <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (mod_q == '0 || base_q >= mod_q) begin
            finish <= 1'b1;
            err    <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            acc    <= (mod_q == N'(1)) ? '0 : N'(1);
            k      <= KW'(N - 1);
            op     <= OP_SQR;
            mul_go <= 1'b1;
            state  <= SQR;
          end
        end
        SQR: begin
          if (mul_done) begin
            acc <= mul_p;
            if (exp_q[k]) begin
              op     <= OP_MUL;
              mul_go <= 1'b1;
              state  <= MUL;
            end else if (k == '0) begin
              state <= DONE;
            end else begin
              k      <= k - 1'b1;
              mul_go <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            acc <= mul_p;
            if (k == '0) begin
              state <= DONE;
            end else begin
              k      <= k - 1'b1;
              op     <= OP_SQR;
              mul_go <= 1'b1;
              state  <= SQR;
            end
          end
        end
        DONE: begin
          result <= acc;
          finish <= 1'b1;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mod_exp_engine.sv
// ---------------------------------------------------------------------------
// tb_rsa_mod_exp_engine
//   Self-checking bench for rsa_mod_exp_engine at WIDTH=16 (N=32), which
//   keeps every job short while still fitting all the directed operands.
// ---------------------------------------------------------------------------
module tb_rsa_mod_exp_engine;

  localparam int W     = 16;
  localparam int N     = 2 * W;
  localparam int LIMIT = 5000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] base;
  logic [N-1:0] exponent;
  logic [N-1:0] modulus;
  logic         busy;
  logic         finish;
  logic         err;
  logic [N-1:0] result;

  int total = 0;
  int bad   = 0;

  rsa_mod_exp_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .finish   (finish),
    .err      (err),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] b;
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic [N-1:0] r;
    logic         er;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: right-to-left binary exponentiation with plain 64-bit arithmetic.
  function automatic logic [N-1:0] ref_pow(input logic [N-1:0] b, input logic [N-1:0] e,
                                           input logic [N-1:0] m);
    longint unsigned r, x, mm;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < N; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return N'(r);
  endfunction

  function automatic int ref_latency(input logic [N-1:0] e, input logic is_err);
    return is_err ? 1 : 2 + N * (N + $countones(e));
  endfunction

  // Drives one start pulse; returns at #1 after the start edge.
  task automatic launch(input logic [N-1:0] b, input logic [N-1:0] e, input logic [N-1:0] m);
    base     = b;
    exponent = e;
    modulus  = m;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input int pre, output int lat, output bit seen);
    lat  = pre;
    seen = 1'b0;
    while (!seen && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
      if (finish) seen = 1'b1;
    end
  endtask

  task automatic run_job(input string name, input logic [N-1:0] b, input logic [N-1:0] e,
                         input logic [N-1:0] m, input logic [N-1:0] exp_r, input logic exp_err);
    int lat;
    bit seen;
    launch(b, e, m);
    check({name, "_busy_start"}, 64'(busy), 64'd1);
    check({name, "_result_cleared"}, 64'(result), 64'd0);
    wait_finish(0, lat, seen);
    check({name, "_finish_seen"}, 64'(seen), 64'd1);
    check({name, "_result"}, 64'(result), 64'(exp_r));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_latency"}, 64'(lat), 64'(ref_latency(e, exp_err)));
    check({name, "_busy_at_finish"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  pulses;
    logic [N-1:0] rb, re, rm;

    vecs[0] = '{b: 4,   e: 13, m: 497, r: 445, er: 0};
    vecs[1] = '{b: 4,   e: 0,  m: 497, r: 1,   er: 0};
    vecs[2] = '{b: 0,   e: 5,  m: 1,   r: 0,   er: 0};
    vecs[3] = '{b: 0,   e: 9,  m: 497, r: 0,   er: 0};
    vecs[4] = '{b: 496, e: 2,  m: 497, r: 1,   er: 0};
    vecs[5] = '{b: 5,   e: 3,  m: 0,   r: 0,   er: 1};
    vecs[6] = '{b: 500, e: 3,  m: 497, r: 0,   er: 1};
    vecs[7] = '{b: 497, e: 1,  m: 497, r: 0,   er: 1};
    vecs[8] = '{b: 0,   e: 0,  m: 1,   r: 0,   er: 0};

    reset    = 1'b1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].r, vecs[i].er);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_finish_pulse", i), 64'(finish), 64'd0);
      check($sformatf("vec%0d_result_held", i), 64'(result), 64'(vecs[i].r));
    end

    // RSA round trip, decrypt started in the encrypt finish cycle.
    run_job("encrypt", 65, 17, 3233, 2790, 1'b0);
    run_job("decrypt", 2790, 2753, 3233, 65, 1'b0);
    @(posedge clk);
    #1;

    // Reset partway through a job.
    launch(4, 13, 497);
    repeat (1000) @(posedge clk);
    #2;
    check("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_finish", 64'(finish), 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pulses = 0;
    repeat (1200) begin
      @(posedge clk);
      #1;
      if (finish) pulses++;
    end
    check("midrst_no_finish", 64'(pulses), 64'd0);
    run_job("after_rst", 4, 13, 497, 445, 1'b0);
    @(posedge clk);
    #1;

    // A start while busy must not disturb the running job.
    launch(4, 13, 497);
    repeat (100) @(posedge clk);
    #1;
    base     = 65;
    exponent = 17;
    modulus  = 3233;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_finish(101, lat, seen);
    check("ignore_finish_seen", 64'(seen), 64'd1);
    check("ignore_result", 64'(result), 64'd445);
    check("ignore_latency", 64'(lat), 64'(ref_latency(32'd13, 1'b0)));
    @(posedge clk);
    #1;
    check("ignore_idle_after", 64'(busy), 64'd0);

    // Randomized jobs against the reference model.
    for (int i = 0; i < 14; i++) begin
      rm = ($urandom_range(0, 3) == 0) ? N'($urandom_range(2, 1000)) : N'($urandom);
      if (rm == '0) rm = 3;
      rb = N'($urandom) % rm;
      re = N'($urandom);
      run_job($sformatf("rand%0d", i), rb, re, rm, ref_pow(rb, re, rm), 1'b0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
